// File: rtl/common.sv
// Shared MEM-stage encodings: funct3 load/store codes and the stage FSM state type.
package common;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    // log2 of the access width in bytes
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/temp_storage.sv
// Pipeline records between execute, memory access and writeback.
package temp_storage;

    typedef struct packed {
        logic [63:0] alu_result;
        logic [63:0] reg2_value;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  reg_dest_addr;
    } ex_mem;

    typedef struct packed {
        logic [63:0] result;
        logic        reg_write;
        logic [4:0]  reg_dest_addr;
        logic        misalign;
    } mem_wb;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the data bus: store strobe/data placement,
// load extract and sign/zero extension, and misalignment detection.
module mem_align
    import common::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]          addr_off,
    input  logic [2:0]          funct3,
    input  logic [63:0]         reg2_value,
    input  logic [DATA_W-1:0]   dresp_data,
    output logic                misalign,
    output logic [DATA_W/8-1:0] strobe,
    output logic [DATA_W-1:0]   store_data,
    output logic [63:0]         load_data
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        size;
    logic              zero_ext;
    logic [5:0]        bit_off;
    logic [DATA_W-1:0] shifted;
    logic [63:0]       lane;
    logic [STRB_W-1:0] size_mask;

    always_comb begin
        size       = access_size(funct3);
        zero_ext   = funct3[2];
        bit_off    = {addr_off, 3'b000};
        shifted    = dresp_data >> bit_off;
        lane       = shifted[63:0];
        store_data = DATA_W'(reg2_value) << bit_off;
        misalign   = 1'b0;
        size_mask  = '0;
        load_data  = lane;
        case (size)
            2'd0: begin
                size_mask = STRB_W'(8'h01);
                load_data = zero_ext ? {56'b0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
            end
            2'd1: begin
                misalign  = addr_off[0];
                size_mask = STRB_W'(8'h03);
                load_data = zero_ext ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            end
            2'd2: begin
                misalign  = |addr_off[1:0];
                size_mask = STRB_W'(8'h0F);
                load_data = zero_ext ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            end
            default: begin
                misalign  = |addr_off;
                size_mask = STRB_W'(8'hFF);
                load_data = lane;
            end
        endcase
        strobe = size_mask << addr_off;
    end

endmodule

// File: rtl/memory_access.sv
// RV64 MEM stage: issues loads/stores on the data bus and registers the
// aligned result into the mem_wb record for writeback.
//
//   state | meaning
//   IDLE  | empty, ready for a new instruction
//   BUS   | bus request outstanding, waiting for dresp_ok
//   HOLD  | mem_wb_state valid, waiting for writeback to take it
module memory_access
    import common::*, temp_storage::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  ex_mem               ex_mem_state,
    output logic                out_valid,
    input  logic                out_ready,
    output mem_wb               mem_wb_state,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic                dreq_write,
    output logic [2:0]          dreq_size,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_ok,
    input  logic [DATA_W-1:0]   dresp_data
);

    mem_state_t state, state_nxt;

    logic                accept;
    logic                is_mem;
    logic [2:0]          lat_off;
    logic [2:0]          lat_funct3;
    logic                lat_write;
    logic                lat_reg_write;
    logic [4:0]          lat_rd;

    logic [2:0]          sel_off;
    logic [2:0]          sel_funct3;
    logic                misalign_a;
    logic [DATA_W/8-1:0] strobe_a;
    logic [DATA_W-1:0]   store_data_a;
    logic [63:0]         load_data_a;

    assign is_mem = ex_mem_state.mem_read | ex_mem_state.mem_write;
    assign accept = in_valid & in_ready;

    // The aligner serves the response path while in BUS, the request path otherwise.
    assign sel_off    = (state == BUS) ? lat_off    : ex_mem_state.alu_result[2:0];
    assign sel_funct3 = (state == BUS) ? lat_funct3 : ex_mem_state.funct3;

    mem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .addr_off   (sel_off),
        .funct3     (sel_funct3),
        .reg2_value (ex_mem_state.reg2_value),
        .dresp_data (dresp_data),
        .misalign   (misalign_a),
        .strobe     (strobe_a),
        .store_data (store_data_a),
        .load_data  (load_data_a)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            BUS: begin
                if (dreq_valid && dresp_ok) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (in_valid && in_ready) begin
            state_nxt = (is_mem && !misalign_a) ? BUS : HOLD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dreq_valid    <= 1'b0;
            dreq_addr     <= '0;
            dreq_write    <= 1'b0;
            dreq_size     <= '0;
            dreq_strobe   <= '0;
            dreq_data     <= '0;
            lat_off       <= '0;
            lat_funct3    <= '0;
            lat_write     <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_rd        <= '0;
            mem_wb_state  <= '0;
        end else if (accept) begin
            if (is_mem && !misalign_a) begin
                // both mem_read and mem_write set resolves to a store
                dreq_valid    <= 1'b1;
                dreq_addr     <= {ex_mem_state.alu_result[ADDR_W-1:3], 3'b000};
                dreq_write    <= ex_mem_state.mem_write;
                dreq_size     <= {1'b0, access_size(ex_mem_state.funct3)};
                dreq_strobe   <= ex_mem_state.mem_write ? strobe_a : '0;
                dreq_data     <= ex_mem_state.mem_write ? store_data_a : '0;
                lat_off       <= ex_mem_state.alu_result[2:0];
                lat_funct3    <= ex_mem_state.funct3;
                lat_write     <= ex_mem_state.mem_write;
                lat_reg_write <= ex_mem_state.reg_write;
                lat_rd        <= ex_mem_state.reg_dest_addr;
            end else if (is_mem) begin
                mem_wb_state.result        <= '0;
                mem_wb_state.reg_write     <= 1'b0;
                mem_wb_state.reg_dest_addr <= ex_mem_state.reg_dest_addr;
                mem_wb_state.misalign      <= 1'b1;
            end else begin
                mem_wb_state.result        <= ex_mem_state.alu_result;
                mem_wb_state.reg_write     <= ex_mem_state.reg_write;
                mem_wb_state.reg_dest_addr <= ex_mem_state.reg_dest_addr;
                mem_wb_state.misalign      <= 1'b0;
            end
        end else if (state == BUS && dreq_valid && dresp_ok) begin
            dreq_valid                 <= 1'b0;
            mem_wb_state.result        <= lat_write ? 64'd0 : load_data_a;
            mem_wb_state.reg_write     <= lat_reg_write;
            mem_wb_state.reg_dest_addr <= lat_rd;
            mem_wb_state.misalign      <= 1'b0;
        end
    end

endmodule
